// File: rtl/calc_alu_seq.sv
// calc_alu_seq: clocked unsigned ADD/SUB/MUL/DIV calculator core with a
// start/busy/done handshake. ADD, SUB and divide-by-zero finish in a single
// execute cycle. MUL (shift-add) and DIV (restoring) work one bit per clock.
// Optional feature macro: CALC_REM_EN. When it is defined, the DIV remainder
// is kept and driven on rem_o. When it is undefined, rem_o is tied to zero.
module calc_alu_seq #(
    parameter int WIDTH = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             on_off_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic             div_zero_o,
    output logic [3:0]       op_led_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 ovf_q, ovf_d;
    logic                 divZero_q, divZero_d;
    logic [3:0]           opLed_q, opLed_d;
`ifdef CALC_REM_EN
    logic [WIDTH-1:0]     rem_q, rem_d;
`endif

    logic [WIDTH:0]       addSum;
    logic [WIDTH:0]       subDiff;
    logic [WIDTH:0]       mulSum;
    logic [WIDTH:0]       divShift;
    logic [WIDTH-1:0]     divDiff;
    logic                 divBit;
    logic [WIDTH-1:0]     divRem;

    // State and datapath registers. Reset overrides power and start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            divZero_q <= 1'b0;
            opLed_q   <= '0;
`ifdef CALC_REM_EN
            rem_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            divZero_q <= divZero_d;
            opLed_q   <= opLed_d;
`ifdef CALC_REM_EN
            rem_q     <= rem_d;
`endif
        end
    end

    // Next-state logic and arithmetic.
    // work_q holds {high, low}. For MUL this is {partial product, multiplier}.
    // For DIV this is {partial remainder, dividend/quotient}.
    // RUN spends WIDTH bit-steps followed by one write-back cycle.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        divZero_d = divZero_q;
        opLed_d   = opLed_q;
`ifdef CALC_REM_EN
        rem_d     = rem_q;
`endif

        addSum   = {1'b0, a_q} + {1'b0, b_q};
        subDiff  = {1'b0, a_q} - {1'b0, b_q};
        mulSum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_q} : '0);
        divShift = work_q[2*WIDTH-1:WIDTH-1];
        divDiff  = divShift[WIDTH-1:0] - b_q;
        divBit   = (divShift >= {1'b0, b_q});
        divRem   = divBit ? divDiff : divShift[WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (start_i && on_off_i) begin
                    op_d      = op_i;
                    a_d       = a_i;
                    b_d       = b_i;
                    ovf_d     = 1'b0;
                    divZero_d = 1'b0;
                    opLed_d   = 4'b0001 << op_i;
                    cnt_d     = '0;
                    if (op_i == OP_MUL) begin
                        work_d  = {{WIDTH{1'b0}}, b_i};
                        state_d = RUN;
                    end else if (op_i[1] && (b_i != '0)) begin
                        work_d  = {{WIDTH{1'b0}}, a_i};
                        state_d = RUN;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d = DONE;
                case (op_q)
                    OP_ADD: begin
                        result_d = addSum[WIDTH-1:0];
                        ovf_d    = addSum[WIDTH];
`ifdef CALC_REM_EN
                        rem_d    = '0;
`endif
                    end
                    OP_SUB: begin
                        result_d = subDiff[WIDTH-1:0];
                        ovf_d    = subDiff[WIDTH];
`ifdef CALC_REM_EN
                        rem_d    = '0;
`endif
                    end
                    default: begin
                        result_d  = {WIDTH{1'b1}};
                        divZero_d = 1'b1;
`ifdef CALC_REM_EN
                        rem_d     = a_q;
`endif
                    end
                endcase
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d  = DONE;
                    result_d = work_q[WIDTH-1:0];
                    if (op_q == OP_MUL) begin
                        ovf_d = |work_q[2*WIDTH-1:WIDTH];
`ifdef CALC_REM_EN
                        rem_d = '0;
`endif
                    end else begin
                        ovf_d = 1'b0;
`ifdef CALC_REM_EN
                        rem_d = work_q[2*WIDTH-1:WIDTH];
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q == OP_MUL) begin
                        work_d = {mulSum, work_q[WIDTH-1:1]};
                    end else begin
                        work_d = {divRem, work_q[WIDTH-2:0], divBit};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!on_off_i) begin
            state_d   = IDLE;
            result_d  = '0;
            ovf_d     = 1'b0;
            divZero_d = 1'b0;
            opLed_d   = '0;
`ifdef CALC_REM_EN
            rem_d     = '0;
`endif
        end
    end

    assign result_o   = result_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign ovf_o      = ovf_q;
    assign div_zero_o = divZero_q;
    assign op_led_o   = on_off_i ? opLed_q : 4'b0000;
`ifdef CALC_REM_EN
    assign rem_o      = rem_q;
`else
    assign rem_o      = '0;
`endif

endmodule
